// File: rtl/store_buffer_pkg.sv
// Shared core package: load/store Funct3 encodings, store-buffer defaults
// and the layout of a queued store entry.
package store_buffer_pkg;

    // Load widths (Funct3 of load instructions)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store widths (Funct3 of store instructions)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Default number of queued store entries
    localparam int SB_DEFAULT_DEPTH = 4;

    // One queued store: word address, lane-aligned data, byte enables
    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_packer.sv
// store_packer: combinational store alignment.
// Replicates register data across the byte lanes, builds byte enables from
// the address offset and classifies the store as legal or misaligned.
//   funct3    : store width (SB/SH/SW)
//   offset    : byte offset within the word (address[1:0])
//   wdata     : LSB-justified register data
//   lane_data : lane-aligned write data
//   lane_be   : byte enables, bit i = byte i
//   legal     : well-formed, aligned store that may be enqueued
//   misalign  : SH/SW with an offset the width cannot honour
module store_packer
    import store_buffer_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [31:0] lane_data,
    output logic [3:0]  lane_be,
    output logic        legal,
    output logic        misalign
);

    always_comb begin
        lane_data = wdata;
        lane_be   = 4'b0000;
        legal     = 1'b0;
        misalign  = 1'b0;
        case (funct3)
            F3_SB: begin
                lane_data = {4{wdata[7:0]}};
                lane_be   = 4'b0001 << offset;
                legal     = 1'b1;
            end
            F3_SH: begin
                lane_data = {2{wdata[15:0]}};
                lane_be   = 4'b0011 << offset;
                legal     = ~offset[0];
                misalign  = offset[0];
            end
            F3_SW: begin
                lane_data = wdata;
                lane_be   = 4'b1111;
                legal     = (offset == 2'b00);
                misalign  = (offset != 2'b00);
            end
            // Unknown widths are neither enqueued nor flagged
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: FIFO of committed stores between the M stage and data memory.
//   CLK, RESET          : clock, synchronous active-high reset
//   StoreReqM, Funct3M,
//   AddressM, WriteDataM: store (or load address) presented by the M stage
//   LoadReqM            : load in M; LoadHazardM flags a pending same-word store
//   StoreStallM         : store in M while the buffer is full
//   MisalignM           : current store is misaligned and dropped
//   MemWrite*           : valid/ready write port to data memory (head entry)
//   Empty               : nothing pending (fence / drain)
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEFAULT_DEPTH
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        StoreReqM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] AddressM,
    input  logic [31:0] WriteDataM,
    input  logic        LoadReqM,
    output logic        StoreStallM,
    output logic        MisalignM,
    output logic        LoadHazardM,
    output logic        MemWriteValid,
    input  logic        MemWriteReady,
    output logic [31:0] MemWriteAddr,
    output logic [31:0] MemWriteData,
    output logic [3:0]  MemWriteBE,
    output logic        Empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    sb_entry_t          entry_mem [DEPTH];
    logic [DEPTH-1:0]   valid_reg;
    logic [PW-1:0]      head_reg;
    logic [PW-1:0]      tail_reg;
    logic [CW-1:0]      count_reg;

    logic [31:0]        pack_data;
    logic [3:0]         pack_be;
    logic               pack_legal;
    logic               pack_misalign;
    logic               full;
    logic               enq;
    logic               deq;
    logic [DEPTH-1:0]   addr_hit;
    sb_entry_t          head_entry;

    store_packer u_packer (
        .funct3    (Funct3M),
        .offset    (AddressM[1:0]),
        .wdata     (WriteDataM),
        .lane_data (pack_data),
        .lane_be   (pack_be),
        .legal     (pack_legal),
        .misalign  (pack_misalign)
    );

    // Stall is judged on the registered count only; a dequeue in the same
    // cycle does not free a slot for this store.
    assign full        = (count_reg == FULL_COUNT);
    assign StoreStallM = StoreReqM & full;
    assign MisalignM   = StoreReqM & pack_misalign;

    assign enq = StoreReqM & pack_legal & ~full & ~RESET;
    assign deq = MemWriteValid & MemWriteReady;

    // Head outputs come straight from registered state: no enqueue bypass
    assign head_entry    = entry_mem[head_reg];
    assign MemWriteValid = (count_reg != '0);
    assign MemWriteAddr  = {head_entry.word_addr, 2'b00};
    assign MemWriteData  = head_entry.data;
    assign MemWriteBE    = head_entry.be;
    assign Empty         = (count_reg == '0);

    // Word-granular hazard check against every live entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign addr_hit[gi] = valid_reg[gi] &&
                                  (entry_mem[gi].word_addr == AddressM[31:2]);
        end
    endgenerate
    assign LoadHazardM = LoadReqM & (|addr_hit);

    // Entry storage carries no reset; liveness is tracked by valid_reg
    always_ff @(posedge CLK) begin
        if (enq) begin
            entry_mem[tail_reg] <= '{word_addr: AddressM[31:2],
                                     data:      pack_data,
                                     be:        pack_be};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            if (enq) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (deq) begin
                head_reg <= head_reg + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            // Head and tail never coincide on a simultaneous enq/deq unless
            // the buffer is empty (deq impossible) or full (enq impossible),
            // so the two updates never target the same bit.
            for (int i = 0; i < DEPTH; i++) begin
                if (enq && (tail_reg == PW'(i))) begin
                    valid_reg[i] <= 1'b1;
                end else if (deq && (head_reg == PW'(i))) begin
                    valid_reg[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StoreReqM = 1'b0;
    logic [2:0]  Funct3M = 3'b000;
    logic [31:0] AddressM = '0;
    logic [31:0] WriteDataM = '0;
    logic        LoadReqM = 1'b0;
    logic        StoreStallM;
    logic        MisalignM;
    logic        LoadHazardM;
    logic        MemWriteValid;
    logic        MemWriteReady = 1'b0;
    logic [31:0] MemWriteAddr;
    logic [31:0] MemWriteData;
    logic [3:0]  MemWriteBE;
    logic        Empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .CLK           (clk),
        .RESET         (rst),
        .StoreReqM     (StoreReqM),
        .Funct3M       (Funct3M),
        .AddressM      (AddressM),
        .WriteDataM    (WriteDataM),
        .LoadReqM      (LoadReqM),
        .StoreStallM   (StoreStallM),
        .MisalignM     (MisalignM),
        .LoadHazardM   (LoadHazardM),
        .MemWriteValid (MemWriteValid),
        .MemWriteReady (MemWriteReady),
        .MemWriteAddr  (MemWriteAddr),
        .MemWriteData  (MemWriteData),
        .MemWriteBE    (MemWriteBE),
        .Empty         (Empty)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        StoreReqM  = 1'b1;
        Funct3M    = f3;
        AddressM   = a;
        WriteDataM = d;
        #1;
    endtask

    task automatic idle();
        StoreReqM = 1'b0;
        LoadReqM  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MemWriteReady = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (MemWriteValid !== 1'b0 || Empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_state valid=%b empty=%b expected valid=0 empty=1", MemWriteValid, Empty);
        end
        set_store(F3_SW, 32'h0000_0100, 32'h1);
        checks++;
        if (StoreStallM !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_stall stall=%b expected 0", StoreStallM);
        end
        idle();
        $display("test_reset done: valid=%b empty=%b", MemWriteValid, Empty);
    endtask

    task automatic test_sb();
        MemWriteReady = 1'b1;
        set_store(F3_SB, 32'h0000_1003, 32'h0000_00AB);
        tick();
        idle();
        checks++;
        if (MemWriteValid !== 1'b1 || MemWriteAddr !== 32'h0000_1000 ||
            MemWriteData !== 32'hABAB_ABAB || MemWriteBE !== 4'b1000) begin
            errors++;
            $display("FAIL sb_pack valid=%b addr=%h data=%h be=%b expected 1 00001000 ababab ab 1000",
                     MemWriteValid, MemWriteAddr, MemWriteData, MemWriteBE);
        end
        tick();
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL sb_drain empty=%b expected 1", Empty);
        end
        $display("test_sb: SB 0x1003 -> addr=%h data=%h be=%b", 32'h1000, 32'hABABABAB, 4'b1000);
    endtask

    task automatic test_sh();
        MemWriteReady = 1'b0;
        set_store(F3_SH, 32'h0000_2001, 32'h0000_1234);
        checks++;
        if (MisalignM !== 1'b1) begin
            errors++;
            $display("FAIL sh_misalign misalign=%b expected 1", MisalignM);
        end
        tick();
        idle();
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL sh_misalign_dropped empty=%b expected 1", Empty);
        end
        // Misaligned word store also flagged
        set_store(F3_SW, 32'h0000_2002, 32'h5555_5555);
        checks++;
        if (MisalignM !== 1'b1) begin
            errors++;
            $display("FAIL sw_misalign misalign=%b expected 1", MisalignM);
        end
        // Unsupported width: ignored silently
        set_store(3'b011, 32'h0000_2001, 32'h5555_5555);
        checks++;
        if (MisalignM !== 1'b0) begin
            errors++;
            $display("FAIL bad_f3_flag misalign=%b expected 0", MisalignM);
        end
        tick();
        idle();
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL bad_f3_dropped empty=%b expected 1", Empty);
        end
        set_store(F3_SH, 32'h0000_2002, 32'h0000_1234);
        checks++;
        if (MisalignM !== 1'b0) begin
            errors++;
            $display("FAIL sh_aligned_flag misalign=%b expected 0", MisalignM);
        end
        tick();
        idle();
        checks++;
        if (MemWriteValid !== 1'b1 || MemWriteAddr !== 32'h0000_2000 ||
            MemWriteData !== 32'h1234_1234 || MemWriteBE !== 4'b1100) begin
            errors++;
            $display("FAIL sh_pack valid=%b addr=%h data=%h be=%b expected 1 00002000 12341234 1100",
                     MemWriteValid, MemWriteAddr, MemWriteData, MemWriteBE);
        end
        MemWriteReady = 1'b1;
        tick();
        // SB at offset 1 while draining
        set_store(F3_SB, 32'h0000_2101, 32'hFFFF_FF5A);
        tick();
        idle();
        checks++;
        if (MemWriteData !== 32'h5A5A_5A5A || MemWriteBE !== 4'b0010 || MemWriteAddr !== 32'h0000_2100) begin
            errors++;
            $display("FAIL sb_off1 addr=%h data=%h be=%b expected 00002100 5a5a5a5a 0010",
                     MemWriteAddr, MemWriteData, MemWriteBE);
        end
        tick();
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL sh_drain empty=%b expected 1", Empty);
        end
        $display("test_sh: SH 0x2001 misaligned, SH 0x2002 -> data=%h be=%b", 32'h12341234, 4'b1100);
    endtask

    task automatic test_full();
        MemWriteReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_store(F3_SW, 32'h0000_4000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
            checks++;
            if (StoreStallM !== (i == 4)) begin
                errors++;
                $display("FAIL full_stall_%0d stall=%b expected %b", i, StoreStallM, (i == 4));
            end
            tick();
        end
        // Fifth store still held; drain starts but stall stays this cycle
        MemWriteReady = 1'b1;
        #1;
        checks++;
        if (StoreStallM !== 1'b1 || MemWriteData !== 32'h1000_0000) begin
            errors++;
            $display("FAIL full_hold stall=%b data=%h expected 1 10000000", StoreStallM, MemWriteData);
        end
        tick();
        checks++;
        if (StoreStallM !== 1'b0 || MemWriteData !== 32'h1000_0001) begin
            errors++;
            $display("FAIL full_release stall=%b data=%h expected 0 10000001", StoreStallM, MemWriteData);
        end
        tick();
        idle();
        for (int k = 2; k < 5; k++) begin
            checks++;
            if (MemWriteValid !== 1'b1 || MemWriteData !== 32'h1000_0000 + 32'(k) ||
                MemWriteAddr !== 32'h0000_4000 + 32'(4 * k)) begin
                errors++;
                $display("FAIL full_order_%0d valid=%b addr=%h data=%h expected 1 %h %h", k,
                         MemWriteValid, MemWriteAddr, MemWriteData,
                         32'h0000_4000 + 32'(4 * k), 32'h1000_0000 + 32'(k));
            end
            tick();
        end
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL full_drained empty=%b expected 1", Empty);
        end
        $display("test_full: 5 SW with Ready=0, stall on 5th, drained in order");
    endtask

    task automatic test_hazard();
        MemWriteReady = 1'b0;
        set_store(F3_SW, 32'h0000_3000, 32'hDEAD_BEEF);
        tick();
        idle();
        LoadReqM = 1'b1;
        AddressM = 32'h0000_3002;
        #1;
        checks++;
        if (LoadHazardM !== 1'b1) begin
            errors++;
            $display("FAIL hazard_hit hazard=%b expected 1", LoadHazardM);
        end
        AddressM = 32'h0000_3004;
        #1;
        checks++;
        if (LoadHazardM !== 1'b0) begin
            errors++;
            $display("FAIL hazard_miss hazard=%b expected 0", LoadHazardM);
        end
        LoadReqM = 1'b0;
        AddressM = 32'h0000_3000;
        #1;
        checks++;
        if (LoadHazardM !== 1'b0) begin
            errors++;
            $display("FAIL hazard_noload hazard=%b expected 0", LoadHazardM);
        end
        MemWriteReady = 1'b1;
        tick();
        LoadReqM = 1'b1;
        #1;
        checks++;
        if (LoadHazardM !== 1'b0) begin
            errors++;
            $display("FAIL hazard_after_drain hazard=%b expected 0", LoadHazardM);
        end
        idle();
        $display("test_hazard: load 0x3002 hit, 0x3004 miss");
    endtask

    task automatic test_back_to_back();
        MemWriteReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_store(F3_SW, 32'h0000_5000 + 32'(4 * i), 32'h5000_0000 + 32'(i));
            tick();
        end
        MemWriteReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_store(F3_SW, 32'h0000_5000 + 32'(4 * (k + 2)), 32'h5000_0000 + 32'(k + 2));
            checks++;
            if (MemWriteData !== 32'h5000_0000 + 32'(k) || MemWriteAddr !== 32'h0000_5000 + 32'(4 * k)) begin
                errors++;
                $display("FAIL b2b_head_%0d addr=%h data=%h expected %h %h", k, MemWriteAddr,
                         MemWriteData, 32'h0000_5000 + 32'(4 * k), 32'h5000_0000 + 32'(k));
            end
            tick();
            checks++;
            if (Empty !== 1'b0 || StoreStallM !== 1'b0) begin
                errors++;
                $display("FAIL b2b_level_%0d empty=%b stall=%b expected 0 0", k, Empty, StoreStallM);
            end
        end
        idle();
        for (int k = 10; k < 12; k++) begin
            checks++;
            if (MemWriteValid !== 1'b1 || MemWriteData !== 32'h5000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL b2b_tail_%0d valid=%b data=%h expected 1 %h", k, MemWriteValid,
                         MemWriteData, 32'h5000_0000 + 32'(k));
            end
            tick();
        end
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drained empty=%b expected 1", Empty);
        end
        $display("test_back_to_back: 10 enq+deq cycles at level 2");
    endtask

    task automatic test_reset_mid();
        MemWriteReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_store(F3_SW, 32'h0000_7000 + 32'(4 * i), 32'h7000_0000 + 32'(i));
            tick();
        end
        idle();
        checks++;
        if (MemWriteValid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pending valid=%b expected 1", MemWriteValid);
        end
        // Store presented during reset must not be captured
        rst = 1'b1;
        set_store(F3_SW, 32'h0000_7100, 32'h7100_0000);
        tick();
        rst = 1'b0;
        idle();
        checks++;
        if (MemWriteValid !== 1'b0 || Empty !== 1'b1) begin
            errors++;
            $display("FAIL rmid_cleared valid=%b empty=%b expected 0 1", MemWriteValid, Empty);
        end
        MemWriteReady = 1'b1;
        set_store(F3_SW, 32'h0000_6000, 32'hCAFE_F00D);
        tick();
        idle();
        checks++;
        if (MemWriteValid !== 1'b1 || MemWriteAddr !== 32'h0000_6000 || MemWriteData !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rmid_after valid=%b addr=%h data=%h expected 1 00006000 cafef00d",
                     MemWriteValid, MemWriteAddr, MemWriteData);
        end
        tick();
        checks++;
        if (Empty !== 1'b1) begin
            errors++;
            $display("FAIL rmid_drain empty=%b expected 1", Empty);
        end
        $display("test_reset_mid: reset with 3 pending cleared buffer");
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_full();
        test_hazard();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: StoreBuffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued store entries (power of two, at least 2).
REQ-002 SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port StoreReqM, input, 1 bit, a store instruction is in the M stage this cycle.
REQ-005 SHALL have port Funct3M, input, 3 bits, store width: 000 SB, 001 SH, 010 SW.
REQ-006 SHALL have port AddressM, input, 32 bits, byte address of the store or load.
REQ-007 SHALL have port WriteDataM, input, 32 bits, unaligned register data, LSB-justified.
REQ-008 SHALL have port LoadReqM, input, 1 bit, a load is in the M stage this cycle.
REQ-009 SHALL have port StoreStallM, output, 1 bit, pipeline must hold M because the buffer is full.
REQ-010 SHALL have port MisalignM, output, 1 bit, the current store is misaligned and is dropped.
REQ-011 SHALL have port LoadHazardM, output, 1 bit, the load word address matches a pending store.
REQ-012 SHALL have port MemWriteValid, output, 1 bit, the head entry is presented to data memory.
REQ-013 SHALL have port MemWriteReady, input, 1 bit, data memory accepts the head entry.
REQ-014 SHALL have port MemWriteAddr, output, 32 bits, word-aligned address with [1:0]=00.
REQ-015 SHALL have port MemWriteData, output, 32 bits, lane-aligned write data.
REQ-016 SHALL have port MemWriteBE, output, 4 bits, byte-lane enables, bit i = byte i.
REQ-017 SHALL have port Empty, output, 1 bit, no pending entries, used for fence and drain.

Function
REQ-018 SHALL pack stores with off=AddressM[1:0]: SB data={4{WriteDataM[7:0]}}, BE=0001<<off; SH data={2{WriteDataM[15:0]}}, BE=0011<<off; SW data=WriteDataM, BE=1111.
REQ-019 SHALL drive MisalignM=1 combinationally for SH with off[0]=1, or SW with off!=00; the store is not enqueued.
REQ-020 SHALL silently ignore StoreReqM with any other Funct3M: no enqueue and no flag.
REQ-021 SHALL drive StoreStallM = StoreReqM & full, where full means count==DEPTH; a same-cycle drain does not lift the stall.
REQ-022 SHALL enqueue {addr[31:2], data, BE} when StoreReqM, the store is legal and the buffer is not full; count increments modulo pointer wrap.
REQ-023 SHALL use FIFO order; head pointer and tail pointer each wrap from DEPTH-1 to 0.
REQ-024 SHALL drive MemWriteValid = (count!=0) from registered state, giving latency from enqueue into an empty buffer to MemWriteValid of exactly 1 cycle, with no bypass.
REQ-025 SHALL dequeue on MemWriteValid & MemWriteReady; the head outputs SHALL stay stable while Valid & !Ready.
REQ-026 SHALL leave count unchanged on simultaneous enqueue and dequeue; both pointers advance.
REQ-027 SHALL drive LoadHazardM = LoadReqM & (some valid entry has addr[31:2]==AddressM[31:2]), combinationally, ignoring BE.
REQ-028 SHALL drive Empty = (count==0).

Reset
REQ-029 SHALL, when RESET is high at a clock edge, set count, head and tail to 0 and discard pending entries; MemWriteValid SHALL be 0 the following cycle even mid-handshake.
REQ-030 SHALL not enqueue during a RESET cycle; entry data need not be reset.
REQ-031 SHALL have the following outputs after reset: MemWriteValid=0, Empty=1; StoreStallM, MisalignM and LoadHazardM follow inputs with count=0.

Structure
REQ-032 SHALL place store Funct3 codes (SB/SH/SW) and DEPTH default in the shared core package alongside the load Funct3 codes.
REQ-033 SHALL implement the alignment/BE/misalign logic of REQ-018/019 as combinational sub-module StorePacker, instanced once.

Verification
REQ-034 SHALL be verified with SB at 0x1003 with data 0x000000AB, Ready=1: one cycle later Valid=1, Addr=0x1000, Data=0xABABABAB, BE=1000.
REQ-035 SHALL be verified with SH at 0x2001: MisalignM=1, no enqueue, Empty stays 1; SH at 0x2002 with data 0x1234 gives Data=0x12341234, BE=1100.
REQ-036 SHALL be verified with Ready=0 and 5 SW stores (DEPTH=4): the 5th cycle gives StoreStallM=1 and count=4; then Ready=1 drains entries in order, stall drops after the first dequeue.
REQ-037 SHALL be verified with SW 0x3000 pending and Ready=0, then a load at 0x3002: LoadHazardM=1; a load at 0x3004: LoadHazardM=0.
REQ-038 SHALL be verified by enqueuing and dequeuing in the same cycle at count=2: count stays 2 and pointers wrap correctly over 10 iterations.
REQ-039 SHALL be verified by asserting RESET with 3 entries pending and Valid=1, Ready=0: the next cycle gives Valid=0 and Empty=1; subsequent stores drain normally.
